// File: rtl/insn_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream (word count, then words)
// into 32-bit imem writes starting at BASE_ADDR, then raises run.
module insn_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reload,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] insn_addr,
  output logic [31:0] insn_din,
  output logic        insn_we,
  output logic        run,
  output logic        busy,
  output logic        err,
  output logic [31:0] words_loaded
);

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic [31:0] n_words;
  logic [31:0] word;
  logic        accept;

  assign in_ready = (state == HDR) || (state == DATA);
  // reload wins over a byte offered in the same cycle
  assign accept   = in_valid && in_ready && !reload;
  assign word     = {in_data, partial};
  assign busy     = (state == DATA) || ((state == HDR) && (byte_cnt != 2'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HDR;
      byte_cnt     <= 2'd0;
      partial      <= '0;
      n_words      <= '0;
      insn_we      <= 1'b0;
      insn_addr    <= '0;
      insn_din     <= '0;
      run          <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      insn_we <= 1'b0;
      // run lags DONE entry by a cycle so it rises after the final write pulse
      run     <= (state == DONE);
      if (reload) begin
        state        <= HDR;
        byte_cnt     <= 2'd0;
        partial      <= '0;
        n_words      <= '0;
        run          <= 1'b0;
        err          <= 1'b0;
        words_loaded <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    partial[7:0]   <= in_data;
          2'd1:    partial[15:8]  <= in_data;
          2'd2:    partial[23:16] <= in_data;
          default: ;
        endcase
        if (byte_cnt == 2'd3) begin
          if (state == HDR) begin
            n_words <= word;
            if (word == 32'd0) begin
              state <= DONE;
            end else if (word > MAX_N) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end else begin
            // words_loaded equals the index of the word being completed
            insn_we      <= 1'b1;
            insn_din     <= word;
            insn_addr    <= BASE_ADDR + {words_loaded[29:0], 2'b00};
            words_loaded <= words_loaded + 32'd1;
            if (words_loaded + 32'd1 == n_words) state <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_insn_loader.sv
// Randomized bench for insn_loader: streams are checked against a stream-level model of
// the expected writes, their cycle positions, and the run/err timing.
module tb_insn_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reload;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] insn_addr;
  logic [31:0] insn_din;
  logic        insn_we;
  logic        run;
  logic        busy;
  logic        err;
  logic [31:0] words_loaded;

  insn_loader dut (
    .clk(clk), .reset_n(reset_n), .reload(reload), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
    .run(run), .busy(busy), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int run_cyc;
  int err_cyc;

  logic [7:0]  stream[$];
  int          acc[$];
  int          wr_cyc[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    acc.delete();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    run_cyc = -1;
    err_cyc = -1;
  endtask

  // Called once per negedge: outputs here reflect the preceding posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (insn_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(insn_addr);
      wr_data.push_back(insn_din);
    end
    if (run && run_cyc < 0) run_cyc = cyc;
    if (err && err_cyc < 0) err_cyc = cyc;
  endtask

  // Offer stream bytes in order; an offered byte is taken at the next posedge if in_ready.
  task automatic feed(input int gap, input string tag);
    int idx = 0;
    int budget = 0;
    while (idx < stream.size() && budget < 3000) begin
      tick();
      in_valid = ($urandom_range(99) >= gap);
      in_data  = in_valid ? stream[idx] : 8'($urandom);
      if (in_valid && in_ready) begin
        acc.push_back(cyc);
        idx++;
      end
      budget++;
    end
    check({tag, "_feed_done"}, 32'(idx), 32'(stream.size()));
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      tick();
      in_valid = $urandom_range(1);
      in_data  = 8'($urandom);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Model: a complete stream yields N writes at BASE+4i, each one cycle after its last byte.
  task automatic load(input int gap, input string tag);
    logic [31:0] n;
    int nw;
    int last;
    clear_log();
    feed(gap, tag);
    settle(5);
    if (acc.size() != stream.size()) return;
    n = {stream[3], stream[2], stream[1], stream[0]};
    nw = (n > 32'd4096) ? 0 : int'(n);
    check({tag, "_nwrites"}, 32'(wr_cyc.size()), 32'(nw));
    for (int i = 0; i < nw && i < wr_cyc.size(); i++) begin
      check({tag, "_addr"}, wr_addr[i], 32'h8000_0000 + 32'(4 * i));
      check({tag, "_data"}, wr_data[i],
            {stream[4*i+7], stream[4*i+6], stream[4*i+5], stream[4*i+4]});
      check({tag, "_wr_cycle"}, 32'(wr_cyc[i]), 32'(acc[4*i+7] + 1));
    end
    last = acc[4 + 4*nw - 1];
    if (n > 32'd4096) begin
      check({tag, "_err_cycle"}, 32'(err_cyc), 32'(acc[3] + 1));
      check({tag, "_run"}, 32'(run_cyc), 32'hFFFF_FFFF);
      check({tag, "_err"}, {31'd0, err}, 32'd1);
    end else begin
      check({tag, "_run_cycle"}, 32'(run_cyc), 32'(last + 2));
      check({tag, "_err"}, {31'd0, err}, 32'd0);
    end
    check({tag, "_words"}, words_loaded, 32'(nw));
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reload(input string tag);
    tick();
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    tick();
    reload   = 1'b0;
    in_valid = 1'b0;
    check({tag, "_run"}, {31'd0, run}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_words"}, words_loaded, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
  endtask

  task automatic make_stream(input int n);
    stream.delete();
    push_word(32'(n));
    for (int i = 0; i < n; i++) push_word($urandom);
  endtask

  initial begin
    reset_n  = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear_log();
    repeat (3) tick();
    check("rst_we", {31'd0, insn_we}, 32'd0);
    check("rst_addr", insn_addr, 32'd0);
    check("rst_din", insn_din, 32'd0);
    check("rst_run", {31'd0, run}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_words", words_loaded, 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Two-word program, in_valid held high.
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    load(0, "two_word");
    if (wr_cyc.size() == 2) begin
      check("two_word_w0", wr_data[0], 32'h0000_0013);
      check("two_word_w1", wr_addr[1], 32'h8000_0004);
      check("two_word_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
    end
    do_reload("rl_done");

    // Empty program.
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    load(0, "n_zero");
    do_reload("rl_zero");

    // Oversized header.
    stream = '{8'h01, 8'h10, 8'h00, 8'h00};
    load(0, "n_big");
    do_reload("rl_err");

    // Partial word abandoned by reload, then a fresh one-word load.
    clear_log();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    feed(0, "partial");
    do_reload("rl_partial");
    tick();
    check("partial_nowrite", 32'(wr_cyc.size()), 32'd0);
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(30, "beef");
    if (wr_cyc.size() == 1) begin
      check("beef_data", wr_data[0], 32'hDEAD_BEEF);
      check("beef_addr", wr_addr[0], 32'h8000_0000);
    end
    do_reload("rl_beef");

    // Reload offered together with the last byte of a word: that write must not happen.
    clear_log();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    feed(0, "cancel");
    do_reload("rl_cancel");
    tick();
    check("cancel_nowrite", 32'(wr_cyc.size()), 32'd0);

    // Sixteen words with 50% idle gaps, then several random small programs.
    make_stream(16);
    load(50, "n16");
    do_reload("rl_n16");
    for (int t = 0; t < 4; t++) begin
      make_stream($urandom_range(1, 6));
      load($urandom_range(0, 70), "rand");
      do_reload("rl_rand");
    end

    // Asynchronous reset in the middle of a data word.
    clear_log();
    make_stream(4);
    stream = stream[0:9];
    feed(0, "mid");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, insn_we}, 32'd0);
    check("mid_rst_addr", insn_addr, 32'd0);
    check("mid_rst_din", insn_din, 32'd0);
    check("mid_rst_run", {31'd0, run}, 32'd0);
    check("mid_rst_words", words_loaded, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    make_stream(3);
    load(40, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
